// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit: one-at-a-time load/store initiator for a 64-bit data
// memory. Extracts and extends load lanes; read-modify-writes sub-dword stores.
// Revision: 1.0
// ============================================================================
module load_store_unit #(
  parameter int ADDR_BITS = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [63:0] address,
  output logic [63:0] write_data,
  input  logic [63:0] read_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  r_funct3;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_merge;
  logic [63:0] r_rdata;
  logic        r_err;

  logic        w_misalign;
  logic        w_range_err;
  logic        w_fault;
  logic [5:0]  w_bit_off;
  logic [63:0] w_lane_sh;
  logic [63:0] w_load_ext;
  logic [63:0] w_size_mask;
  logic [63:0] w_mask;
  logic [63:0] w_wdata_sh;
  logic [63:0] w_merged;
  logic        w_mem_rd;
  logic        w_mem_wr;

  always_comb begin
    w_misalign = 1'b0;
    case (req_funct3[1:0])
      2'b01:   w_misalign = req_addr[0];
      2'b10:   w_misalign = |req_addr[1:0];
      2'b11:   w_misalign = |req_addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_range_err = |(req_addr >> ADDR_BITS);
  assign w_fault     = w_misalign | (req_funct3 == 3'b111)
                     | (req_is_store & req_funct3[2]) | w_range_err;

  // Byte offset within the dword, scaled to a bit offset for lane shifting.
  assign w_bit_off = {r_addr[2:0], 3'b000};
  assign w_lane_sh = read_data >> w_bit_off;

  always_comb begin
    w_load_ext = w_lane_sh;
    case (r_funct3[1:0])
      2'b00:   w_load_ext = {{56{~r_funct3[2] & w_lane_sh[7]}},  w_lane_sh[7:0]};
      2'b01:   w_load_ext = {{48{~r_funct3[2] & w_lane_sh[15]}}, w_lane_sh[15:0]};
      2'b10:   w_load_ext = {{32{~r_funct3[2] & w_lane_sh[31]}}, w_lane_sh[31:0]};
      default: w_load_ext = w_lane_sh;
    endcase
  end

  always_comb begin
    w_size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (r_funct3[1:0])
      2'b00:   w_size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   w_size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   w_size_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  assign w_mask     = w_size_mask << w_bit_off;
  assign w_wdata_sh = r_wdata << w_bit_off;
  assign w_merged   = (read_data & ~w_mask) | (w_wdata_sh & w_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_funct3 <= 3'b000;
      r_addr   <= 64'h0;
      r_wdata  <= 64'h0;
      r_merge  <= 64'h0;
      r_rdata  <= 64'h0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_merge  <= 64'h0;
            r_rdata  <= 64'h0;
            r_err    <= w_fault;
            if (w_fault)
              r_state <= S_RESP;
            else if (!req_is_store)
              r_state <= S_LOAD;
            else if (req_funct3[1:0] == 2'b11)
              r_state <= S_WRITE;
            else
              r_state <= S_RMW_RD;
          end
        end
        S_LOAD: begin
          r_rdata <= w_load_ext;
          r_state <= S_RESP;
        end
        S_RMW_RD: begin
          r_merge <= w_merged;
          r_state <= S_WRITE;
        end
        S_WRITE: r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_mem_rd = (r_state == S_LOAD) | (r_state == S_RMW_RD);
  assign w_mem_wr = (r_state == S_WRITE);

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign MemRead    = w_mem_rd;
  assign MemWrite   = w_mem_wr;
  assign address    = (w_mem_rd | w_mem_wr) ? {r_addr[63:3], 3'b000} : 64'h0;
  assign write_data = w_mem_wr ? ((r_funct3[1:0] == 2'b11) ? r_wdata : r_merge) : 64'h0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit: directed + randomized bench with a byte-array memory model.
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [63:0] read_data;

  load_store_unit #(.ADDR_BITS(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT (dwords) and the reference byte image.
  logic [63:0] mem  [0:255];
  logic [7:0]  refm [0:2047];

  assign read_data = mem[address[10:3]];
  always @(posedge clk) if (MemWrite) mem[address[10:3]] <= write_data;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_dword(input int a);
    logic [63:0] v = 64'h0;
    for (int i = 0; i < 8; i++) v |= 64'(refm[(a & ~7) + i]) << (8 * i);
    return v;
  endfunction

  task automatic set_dword(input int a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) refm[(a & ~7) + i] = v[8*i +: 8];
    mem[a >> 3] = v;
  endtask

  task automatic run_req(input logic st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
    int size, ai, lat, nrd, nwr, both, exp_lat, exp_nrd, exp_nwr;
    logic flt, got_addr;
    logic [63:0] exp_rd, exp_wd, obs_addr, obs_wd;
    size = 1 << f3[1:0];
    flt  = (f3 == 3'b111) || (st && f3[2]) || ((a & 64'(size - 1)) != 0) || (a >= 64'd2048);
    ai   = int'(a[10:0]);
    exp_rd = 64'h0;
    exp_wd = 64'h0;
    if (!flt && !st) begin
      for (int i = 0; i < size; i++) exp_rd |= 64'(refm[ai + i]) << (8 * i);
      if (!f3[2] && size < 8 && exp_rd[8*size-1]) exp_rd |= ~64'h0 << (8 * size);
    end
    if (!flt && st) begin
      for (int i = 0; i < size; i++) refm[ai + i] = wd[8*i +: 8];
      exp_wd = ref_dword(ai);
    end
    exp_lat = flt ? 1 : (!st ? 2 : (size == 8 ? 2 : 3));
    exp_nrd = (!flt && (!st || size < 8)) ? 1 : 0;
    exp_nwr = (!flt && st) ? 1 : 0;

    @(negedge clk);
    chk("ready_before", {63'h0, req_ready}, 64'h1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the unit must use latched fields.
    req_valid = 1'b0; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    lat = 1; nrd = 0; nwr = 0; both = 0; got_addr = 1'b0; obs_addr = 64'h0; obs_wd = 64'h0;
    while (!resp_valid && lat < 8) begin
      if (MemRead && MemWrite) both++;
      if (MemRead) nrd++;
      if (MemWrite) begin nwr++; obs_wd = write_data; end
      if ((MemRead || MemWrite) && !got_addr) begin obs_addr = address; got_addr = 1'b1; end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency",   64'(lat), 64'(exp_lat));
    chk("resp_err",  {63'h0, resp_err}, {63'h0, flt});
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("memread_cycles",  64'(nrd), 64'(exp_nrd));
    chk("memwrite_cycles", 64'(nwr), 64'(exp_nwr));
    chk("rd_wr_overlap", 64'(both), 64'h0);
    if (got_addr) chk("address", obs_addr, {a[63:3], 3'b000});
    if (!flt && st) begin
      chk("write_data", obs_wd, exp_wd);
      chk("mem_dword", mem[ai >> 3], exp_wd);
    end
    @(posedge clk); #1;
    chk("resp_one_cycle", {63'h0, resp_valid}, 64'h0);
  endtask

  logic [63:0] ra, rw, seen;
  logic [2:0]  rf;
  logic        rs;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 64'h0; req_wdata = 64'h0;
    for (int d = 0; d < 256; d++) set_dword(d * 8, {$urandom, $urandom});
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'h0, req_ready}, 64'h1);
    chk("rst_ctrl", {60'h0, resp_valid, resp_err, MemRead, MemWrite}, 64'h0);
    chk("rst_address", address, 64'h0);
    chk("rst_wdata", write_data, 64'h0);
    chk("rst_rdata", resp_rdata, 64'h0);
    @(negedge clk); rst_n = 1'b1;

    set_dword(32'h10, 64'h8877665544332211);
    run_req(1'b0, 3'b000, 64'h17, 64'h0);
    chk("lb_lit", resp_rdata, 64'hFFFFFFFFFFFFFF88);
    run_req(1'b0, 3'b100, 64'h17, 64'h0);
    chk("lbu_lit", resp_rdata, 64'h88);
    set_dword(32'h10, 64'h8000000000000000);
    run_req(1'b0, 3'b010, 64'h14, 64'h0);
    chk("lw_lit", resp_rdata, 64'hFFFFFFFF80000000);
    run_req(1'b0, 3'b110, 64'h14, 64'h0);
    chk("lwu_lit", resp_rdata, 64'h0000000080000000);
    set_dword(32'h10, 64'h8877665544332211);
    run_req(1'b1, 3'b000, 64'h13, 64'hAB);
    chk("sb_lit", mem[2], 64'h88776655AB332211);
    run_req(1'b0, 3'b011, 64'h10, 64'h0);
    chk("ld_lit", resp_rdata, 64'h88776655AB332211);
    run_req(1'b1, 3'b011, 64'h20, 64'hDEADBEEFCAFEF00D);
    chk("sd_lit", mem[4], 64'hDEADBEEFCAFEF00D);
    run_req(1'b1, 3'b000, 64'h2F, 64'h5A);
    run_req(1'b1, 3'b010, 64'h2C, 64'h12345678);
    run_req(1'b0, 3'b001, 64'h11, 64'h0);
    chk("lh_mis_err", {63'h0, resp_err}, 64'h1);
    run_req(1'b1, 3'b010, 64'h22, 64'h1);
    run_req(1'b0, 3'b111, 64'h10, 64'h0);
    run_req(1'b1, 3'b011, 64'h800, 64'h1);
    chk("range_err", {63'h0, resp_err}, 64'h1);

    // Reset in the middle of an RMW: no write may reach memory.
    set_dword(32'h30, 64'h0123456789ABCDEF);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 64'h31; req_wdata = 64'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_memread", {63'h0, MemRead}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {61'h0, resp_valid, MemRead, MemWrite}, 64'h0);
    chk("midrst_ready", {63'h0, req_ready}, 64'h1);
    chk("midrst_addr", address, 64'h0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 64'h0;
    repeat (5) begin
      @(posedge clk); #1;
      seen |= {62'h0, MemWrite, resp_valid};
    end
    chk("post_rst_quiet", seen, 64'h0);
    chk("post_rst_mem", mem[6], 64'h0123456789ABCDEF);
    run_req(1'b0, 3'b011, 64'h30, 64'h0);

    for (int k = 0; k < 300; k++) begin
      rs = 1'($urandom);
      rf = 3'($urandom_range(0, 7));
      rw = {$urandom, $urandom};
      ra = 64'($urandom_range(0, 2047));
      if ($urandom_range(0, 1) == 1) ra = ra & ~64'((1 << rf[1:0]) - 1);
      if ($urandom_range(0, 15) == 0) ra = ra | (64'h1 << $urandom_range(11, 63));
      run_req(rs, rf, ra, rw);
    end

    for (int d = 0; d < 256; d++) chk("final_mem", mem[d], ref_dword(d * 8));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
